// File: rtl/camera_view_controller.sv
// Camera view sequencer: turns debounced left/right presses into timed view
// transitions for the renderer, with a one-deep buffer for presses made mid-turn.
module camera_view_controller #(
    parameter int TRANSITION_FRAMES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       enable,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [2:0] camera_view,
    output logic       turning,
    output logic [7:0] turn_progress
);

    typedef enum logic [2:0] {
        ST_ILLEGAL = 3'b000,
        ST_FORWARD = 3'b001,
        ST_FTOL    = 3'b010,
        ST_LEFT    = 3'b011,
        ST_LTOF    = 3'b100,
        ST_FTOR    = 3'b101,
        ST_RIGHT   = 3'b110,
        ST_RTOF    = 3'b111
    } view_state_t;

    typedef enum logic [1:0] {
        PEND_NONE  = 2'b00,
        PEND_LEFT  = 2'b01,
        PEND_RIGHT = 2'b10
    } pending_t;

    localparam logic [7:0] LAST_COUNT = 8'(TRANSITION_FRAMES - 1);

    view_state_t state, state_next;
    pending_t    pending, pending_next;
    logic [7:0]  count, count_next;
    logic        turning_q, turning_next;
    logic        btn_left_q, btn_right_q;

    logic        edge_l, edge_r;
    logic        req_l, req_r;
    logic        eff_l, eff_r;
    logic        tick_done;

    // Simultaneous edges on both buttons cancel each other out.
    always_comb begin
        edge_l = btn_left  & ~btn_left_q;
        edge_r = btn_right & ~btn_right_q;
        req_l  = edge_l & ~edge_r;
        req_r  = edge_r & ~edge_l;
        eff_l  = req_l | (~req_r & ~req_l & (pending == PEND_LEFT));
        eff_r  = req_r | (~req_r & ~req_l & (pending == PEND_RIGHT));
        tick_done = frame_tick && (count == LAST_COUNT);
    end

    always_comb begin
        state_next   = state;
        pending_next = pending;
        count_next   = count;

        if (!enable) begin
            state_next   = ST_FORWARD;
            pending_next = PEND_NONE;
            count_next   = 8'd0;
        end else begin
            case (state)
                ST_FORWARD: begin
                    pending_next = PEND_NONE;
                    count_next   = 8'd0;
                    if (eff_l)
                        state_next = ST_FTOL;
                    else if (eff_r)
                        state_next = ST_FTOR;
                end
                ST_LEFT: begin
                    pending_next = PEND_NONE;
                    count_next   = 8'd0;
                    if (eff_r)
                        state_next = ST_LTOF;
                end
                ST_RIGHT: begin
                    pending_next = PEND_NONE;
                    count_next   = 8'd0;
                    if (eff_l)
                        state_next = ST_RTOF;
                end
                ST_FTOL, ST_LTOF, ST_FTOR, ST_RTOF: begin
                    if (req_l)
                        pending_next = PEND_LEFT;
                    else if (req_r)
                        pending_next = PEND_RIGHT;
                    if (tick_done) begin
                        count_next = 8'd0;
                        case (state)
                            ST_FTOL: state_next = ST_LEFT;
                            ST_FTOR: state_next = ST_RIGHT;
                            default: state_next = ST_FORWARD;
                        endcase
                    end else if (frame_tick) begin
                        count_next = count + 8'd1;
                    end
                end
                default: begin
                    state_next   = ST_FORWARD;
                    pending_next = PEND_NONE;
                    count_next   = 8'd0;
                end
            endcase
        end

        turning_next = (state_next == ST_FTOL) || (state_next == ST_LTOF) ||
                       (state_next == ST_FTOR) || (state_next == ST_RTOF);
    end

    // Edge registers start high so a button held through reset needs a release first.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_FORWARD;
            pending     <= PEND_NONE;
            count       <= 8'd0;
            turning_q   <= 1'b0;
            btn_left_q  <= 1'b1;
            btn_right_q <= 1'b1;
        end else begin
            state       <= state_next;
            pending     <= pending_next;
            count       <= count_next;
            turning_q   <= turning_next;
            btn_left_q  <= btn_left;
            btn_right_q <= btn_right;
        end
    end

    assign camera_view   = state;
    assign turning       = turning_q;
    assign turn_progress = count;

endmodule

// File: tb/tb_camera_view_controller.sv
// Scoreboard bench for camera_view_controller: default-length instance plus a
// single-frame-transition instance driven from shared inputs.
module tb_camera_view_controller;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       enable;
    logic       btn_left;
    logic       btn_right;
    logic [2:0] view_a, view_b;
    logic       turning_a, turning_b;
    logic [7:0] prog_a, prog_b;

    int vectors;
    int miscompares;

    typedef struct {
        bit         which;
        string      name;
        logic [2:0] view;
        logic       turning;
        logic [7:0] prog;
    } exp_t;

    exp_t exp_q[$];
    event sample_now;

    camera_view_controller #(.TRANSITION_FRAMES(8)) dut_a (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right),
        .camera_view(view_a), .turning(turning_a), .turn_progress(prog_a)
    );

    camera_view_controller #(.TRANSITION_FRAMES(1)) dut_b (
        .clk(clk), .reset(reset), .frame_tick(frame_tick), .enable(enable),
        .btn_left(btn_left), .btn_right(btn_right),
        .camera_view(view_b), .turning(turning_b), .turn_progress(prog_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: drains the expectation queue on each falling edge or explicit request.
    initial begin
        exp_t       e;
        logic [2:0] v;
        logic       t;
        logic [7:0] p;
        forever begin
            @(negedge clk or sample_now);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                v = e.which ? view_b    : view_a;
                t = e.which ? turning_b : turning_a;
                p = e.which ? prog_b    : prog_a;
                vectors++;
                if (v !== e.view || t !== e.turning || p !== e.prog) begin
                    miscompares++;
                    $display("[TB] FAIL %s (dut %s): got view=%b turning=%b prog=%0d, want view=%b turning=%b prog=%0d",
                             e.name, e.which ? "b" : "a", v, t, p, e.view, e.turning, e.prog);
                end
            end
        end
    end

    task automatic applyStimulus(input logic l, input logic r, input logic tick, input logic en);
        @(negedge clk);
        btn_left   = l;
        btn_right  = r;
        frame_tick = tick;
        enable     = en;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input bit which, input string name, input logic [2:0] view,
                               input logic turning, input logic [7:0] prog);
        exp_t e;
        e.which   = which;
        e.name    = name;
        e.view    = view;
        e.turning = turning;
        e.prog    = prog;
        exp_q.push_back(e);
    endtask

    // Issue n ticks during a transition starting at progress 'start'; reaching 8 lands in 'dest'.
    task automatic runTurn(input string name, input logic [2:0] view, input int start,
                           input int n, input logic [2:0] dest);
        for (int i = 1; i <= n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
            if (start + i == 8)
                checkOutput(0, name, dest, 1'b0, 8'd0);
            else
                checkOutput(0, name, view, 1'b1, 8'(start + i));
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        btn_left   = 1'b0;
        btn_right  = 1'b0;
        frame_tick = 1'b0;
        reset      = 1'b1;
        @(negedge clk);
        reset      = 1'b0;
    endtask

    initial begin
        int wait_cycles;
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        enable      = 1'b0;
        frame_tick  = 1'b0;
        btn_left    = 1'b0;
        btn_right   = 1'b0;

        #3;
        checkOutput(0, "reset_a", 3'b001, 1'b0, 8'd0);
        checkOutput(1, "reset_b", 3'b001, 1'b0, 8'd0);
        -> sample_now;
        @(negedge clk);
        reset = 1'b0;

        // Left turn and back, with an ignored L while in Left
        applyStimulus(0, 0, 0, 1); checkOutput(0, "idle_fwd", 3'b001, 1'b0, 8'd0);
        applyStimulus(1, 0, 0, 1); checkOutput(0, "ftol_start", 3'b010, 1'b1, 8'd0);
        runTurn("ftol_tick", 3'b010, 0, 8, 3'b011);
        applyStimulus(1, 0, 0, 1); checkOutput(0, "left_drop_l", 3'b011, 1'b0, 8'd0);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "left_hold1", 3'b011, 1'b0, 8'd0);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "left_hold2", 3'b011, 1'b0, 8'd0);
        applyStimulus(0, 1, 0, 1); checkOutput(0, "ltof_start", 3'b100, 1'b1, 8'd0);
        runTurn("ltof_tick", 3'b100, 0, 8, 3'b001);

        // Buffered press: R during FtoL after 3 ticks
        applyStimulus(1, 0, 0, 1); checkOutput(0, "buf_ftol", 3'b010, 1'b1, 8'd0);
        runTurn("buf_ftol_tick", 3'b010, 0, 3, 3'b011);
        applyStimulus(0, 1, 0, 1); checkOutput(0, "buf_press_r", 3'b010, 1'b1, 8'd3);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "buf_wait", 3'b010, 1'b1, 8'd3);
        runTurn("buf_finish", 3'b010, 3, 5, 3'b011);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "buf_consumed", 3'b100, 1'b1, 8'd0);
        runTurn("buf_ltof_tick", 3'b100, 0, 8, 3'b001);

        // Both edges together in Forward are discarded
        applyStimulus(1, 1, 0, 1); checkOutput(0, "both_edges", 3'b001, 1'b0, 8'd0);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "both_after", 3'b001, 1'b0, 8'd0);

        // Enable drop in FtoR at progress 5 with pending L
        applyStimulus(0, 1, 0, 1); checkOutput(0, "ftor_start", 3'b101, 1'b1, 8'd0);
        runTurn("ftor_tick", 3'b101, 0, 5, 3'b110);
        applyStimulus(1, 0, 0, 1); checkOutput(0, "ftor_pend_l", 3'b101, 1'b1, 8'd5);
        applyStimulus(0, 0, 0, 0); checkOutput(0, "enable_drop", 3'b001, 1'b0, 8'd0);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "stale_pend1", 3'b001, 1'b0, 8'd0);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "stale_pend2", 3'b001, 1'b0, 8'd0);

        // Into RtoF, then asynchronous reset between clock edges
        applyStimulus(0, 1, 0, 1); checkOutput(0, "ftor2_start", 3'b101, 1'b1, 8'd0);
        runTurn("ftor2_tick", 3'b101, 0, 8, 3'b110);
        applyStimulus(1, 0, 0, 1); checkOutput(0, "rtof_start", 3'b111, 1'b1, 8'd0);
        runTurn("rtof_tick", 3'b111, 0, 2, 3'b001);
        @(negedge clk);
        #2;
        btn_left   = 1'b1;
        btn_right  = 1'b0;
        frame_tick = 1'b0;
        reset      = 1'b1;
        #1;
        checkOutput(0, "async_reset", 3'b001, 1'b0, 8'd0);
        -> sample_now;

        // Left held across reset release must be released before it counts
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1, 0, 0, 1); checkOutput(0, "held_l1", 3'b001, 1'b0, 8'd0);
        applyStimulus(1, 0, 0, 1); checkOutput(0, "held_l2", 3'b001, 1'b0, 8'd0);
        applyStimulus(0, 0, 0, 1); checkOutput(0, "held_release", 3'b001, 1'b0, 8'd0);
        applyStimulus(1, 0, 0, 1); checkOutput(0, "held_repress", 3'b010, 1'b1, 8'd0);

        // Single-frame transitions on dut_b
        doReset();
        applyStimulus(0, 0, 0, 1);
        checkOutput(0, "post_reset_a", 3'b001, 1'b0, 8'd0);
        checkOutput(1, "post_reset_b", 3'b001, 1'b0, 8'd0);
        applyStimulus(0, 1, 0, 1);
        checkOutput(0, "tf1_press_a", 3'b101, 1'b1, 8'd0);
        checkOutput(1, "tf1_press_b", 3'b101, 1'b1, 8'd0);
        applyStimulus(0, 0, 0, 1); checkOutput(1, "tf1_wait_b", 3'b101, 1'b1, 8'd0);
        applyStimulus(0, 0, 1, 1);
        checkOutput(0, "tf1_tick_a", 3'b101, 1'b1, 8'd1);
        checkOutput(1, "tf1_tick_b", 3'b110, 1'b0, 8'd0);
        applyStimulus(1, 0, 1, 1);
        checkOutput(0, "tf1_entry_a", 3'b101, 1'b1, 8'd2);
        checkOutput(1, "tf1_entry_tick_b", 3'b111, 1'b1, 8'd0);
        applyStimulus(0, 0, 1, 1);
        checkOutput(0, "tf1_last_a", 3'b101, 1'b1, 8'd3);
        checkOutput(1, "tf1_done_b", 3'b001, 1'b0, 8'd0);

        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(negedge clk);
            #1;
            wait_cycles++;
        end
        if (exp_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: got %0d pending expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
